genius_seq_engine: RTL and testbench

// - Parametrised sequence engine for the Genius game: generates a pseudo-random colour sequence,

---
 rtl/genius_seq_engine_pkg.sv | 23 ++
 rtl/genius_seq_engine_if.sv | 39 +++
 rtl/genius_seq_engine_lfsr16.sv | 20 ++
 rtl/genius_seq_engine.sv | 182 ++++++++++++++++++
 tb/tb_genius_seq_engine.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/genius_seq_engine_pkg.sv
// Shared definitions for the Genius sequence engine.
// - FSM state encodings (3-bit, legacy-compatible constants)
// - LFSR feedback mask and default seed
// - lfsr_next(): one Galois step of the 16-bit sequence source
package genius_seq_engine_pkg;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GEN      = 3'd1;
    localparam logic [2:0] S_SHOW_ON  = 3'd2;
    localparam logic [2:0] S_SHOW_OFF = 3'd3;
    localparam logic [2:0] S_WAIT     = 3'd4;
    localparam logic [2:0] S_WIN      = 3'd5;
    localparam logic [2:0] S_LOSE     = 3'd6;

    // x^16 + x^14 + x^13 + x^11 + 1 as a right-shifting Galois mask
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
    endfunction

endpackage

// File: rtl/genius_seq_engine_if.sv
// Bus between the game controller side (divider tick, debounced buttons,
// display/LED logic) and the sequence engine.
// - master: drives tick/start/rev/target/buttons, observes game status
// - slave : the engine
interface genius_seq_engine_if #(
    parameter int N_BTN   = 4,
    parameter int MAX_RND = 16,
    parameter int PW      = 8
);
    localparam int RW = $clog2(MAX_RND + 1);

    logic              tick_i;
    logic              start_i;
    logic              rev_i;
    logic [RW-1:0]     target_i;
    logic [N_BTN-1:0]  btn_i;
    logic [N_BTN-1:0]  leds_o;
    logic [RW-1:0]     round_o;
    logic [PW-1:0]     points_o;
    logic              busy_o;
    logic              play_o;
    logic              match_o;
    logic              end_time_o;
    logic              win_o;
    logic              lose_o;

    modport master (
        output tick_i, start_i, rev_i, target_i, btn_i,
        input  leds_o, round_o, points_o, busy_o, play_o, match_o,
               end_time_o, win_o, lose_o
    );

    modport slave (
        input  tick_i, start_i, rev_i, target_i, btn_i,
        output leds_o, round_o, points_o, busy_o, play_o, match_o,
               end_time_o, win_o, lose_o
    );

endinterface

// File: rtl/genius_seq_engine_lfsr16.sv
// Free-running 16-bit Galois LFSR used as the colour source.
// Ports: clk (rising edge), reset_n (sync, active low, loads SEED), q (state).
// Steps every cycle out of reset, so the colour drawn depends on how long
// the player took -- that is the intended source of randomness.
module lfsr16
    import genius_seq_engine_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (!reset_n) q <= SEED;
        else          q <= lfsr_next(q);
    end

endmodule

// File: rtl/genius_seq_engine.sv
// Genius game sequence engine: draws a colour per round from the LFSR,
// plays the stored sequence on the LEDs at tick pace, then checks the
// player's presses (forward or reversed order) with a per-press timeout.
// Ports:
//   CLOCK_50 - system clock, rising edge
//   reset_n  - synchronous reset, active low
//   bus      - slave side of genius_seq_engine_if (tick, start, rev, target,
//              buttons in; leds, round, points, busy/play/match/end_time/
//              win/lose status out)
module genius_seq_engine
    import genius_seq_engine_pkg::*;
#(
    parameter int          N_BTN   = 4,
    parameter int          MAX_RND = 16,
    parameter int          PW      = 8,
    parameter int          SHOW_TK = 2,
    parameter int          TOUT_TK = 5,
    parameter logic [15:0] SEED    = LFSR_SEED
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    genius_seq_engine_if.slave bus
);

    localparam int IW = $clog2(N_BTN);
    localparam int RW = $clog2(MAX_RND + 1);
    localparam int AW = $clog2(MAX_RND);
    localparam int SW = $clog2(SHOW_TK + 1);
    localparam int TW = $clog2(TOUT_TK + 1);

    logic [2:0]       state;
    logic [IW-1:0]    seq [MAX_RND];
    logic [RW-1:0]    round;
    logic [RW-1:0]    idx;
    logic [RW-1:0]    target;
    logic [SW-1:0]    show_cnt;
    logic [TW-1:0]    timer;
    logic [PW-1:0]    points;
    logic             rev;
    logic             match;
    logic             end_time;
    logic [N_BTN-1:0] flash;
    logic [15:0]      lfsr;
    logic             lfsr_unused;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk     (CLOCK_50),
        .reset_n (reset_n),
        .q       (lfsr)
    );

    // Only the low IW bits pick a colour.
    assign lfsr_unused = ^lfsr[15:IW];

    // Expected colour for the current press; reverse mode walks from the
    // newest entry back to the oldest.
    logic [RW-1:0]    exp_idx;
    logic [IW-1:0]    exp_col;
    logic [N_BTN-1:0] exp_hot;
    logic             press_ok;
    logic             last_press;
    logic [RW-1:0]    start_target;

    always_comb begin
        exp_idx      = rev ? (round - RW'(1) - idx) : idx;
        exp_col      = seq[AW'(exp_idx)];
        exp_hot      = N_BTN'(1) << exp_col;
        // Comparing against a one-hot rejects multi-bit presses as well.
        press_ok     = (bus.btn_i == exp_hot);
        last_press   = ((idx + RW'(1)) == round);
        start_target = (bus.target_i == '0 || bus.target_i > RW'(MAX_RND))
                       ? RW'(MAX_RND) : bus.target_i;
    end

    // Sequence store is deliberately not reset; entries are always written
    // before they are read in a game.
    always_ff @(posedge CLOCK_50) begin
        if (state == S_GEN) seq[AW'(round)] <= lfsr[IW-1:0];
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            round    <= '0;
            idx      <= '0;
            target   <= '0;
            show_cnt <= '0;
            timer    <= '0;
            points   <= '0;
            rev      <= 1'b0;
            match    <= 1'b0;
            end_time <= 1'b0;
            flash    <= '0;
        end else begin
            match <= 1'b0;
            flash <= '0;
            case (state)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (bus.start_i) begin
                        state    <= S_GEN;
                        round    <= '0;
                        idx      <= '0;
                        points   <= '0;
                        end_time <= 1'b0;
                        rev      <= bus.rev_i;
                        target   <= start_target;
                    end
                end
                S_GEN: begin
                    round    <= round + RW'(1);
                    idx      <= '0;
                    show_cnt <= '0;
                    state    <= S_SHOW_ON;
                end
                S_SHOW_ON: begin
                    if (bus.tick_i) begin
                        if (show_cnt == SW'(SHOW_TK - 1)) begin
                            show_cnt <= '0;
                            state    <= S_SHOW_OFF;
                        end else begin
                            show_cnt <= show_cnt + SW'(1);
                        end
                    end
                end
                S_SHOW_OFF: begin
                    if (bus.tick_i) begin
                        if ((idx + RW'(1)) < round) begin
                            idx   <= idx + RW'(1);
                            state <= S_SHOW_ON;
                        end else begin
                            idx   <= '0;
                            timer <= TW'(TOUT_TK);
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // A press in the same cycle as a tick takes priority and
                    // reloads the timer, so the tick never counts.
                    if (bus.btn_i != '0) begin
                        if (press_ok) begin
                            match <= 1'b1;
                            flash <= bus.btn_i;
                            idx   <= idx + RW'(1);
                            timer <= TW'(TOUT_TK);
                            if (points != '1) points <= points + PW'(1);
                            if (last_press) state <= (round == target) ? S_WIN : S_GEN;
                        end else begin
                            state <= S_LOSE;
                        end
                    end else if (bus.tick_i) begin
                        if (timer <= TW'(1)) begin
                            end_time <= 1'b1;
                            state    <= S_LOSE;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Playback shows the stored colour; after a correct press the pressed
    // button echoes for one cycle; WIN/LOSE/IDLE keep the LEDs dark.
    always_comb begin
        if (state == S_SHOW_ON)                          bus.leds_o = N_BTN'(1) << seq[AW'(idx)];
        else if (state == S_WAIT || state == S_GEN)      bus.leds_o = flash;
        else                                             bus.leds_o = '0;
    end

    assign bus.round_o    = round;
    assign bus.points_o   = points;
    assign bus.busy_o     = !(state == S_IDLE || state == S_WIN || state == S_LOSE);
    assign bus.play_o     = (state == S_SHOW_ON) || (state == S_SHOW_OFF);
    assign bus.match_o    = match;
    assign bus.end_time_o = end_time;
    assign bus.win_o      = (state == S_WIN);
    assign bus.lose_o     = (state == S_LOSE);

endmodule

// File: tb/tb_genius_seq_engine.sv
// Directed bench for genius_seq_engine with a colour-sequence scoreboard:
// expected LED playback is queued when a round is generated and popped as
// the engine plays each entry; presses are judged by a small game model.
module tb_genius_seq_engine;

    localparam int          N_BTN   = 4;
    localparam int          MAX_RND = 24;
    localparam int          PW      = 8;
    localparam int          SHOW_TK = 2;
    localparam int          TOUT_TK = 5;
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          RW      = $clog2(MAX_RND + 1);

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    genius_seq_engine_if #(.N_BTN(N_BTN), .MAX_RND(MAX_RND), .PW(PW)) bus ();

    genius_seq_engine #(
        .N_BTN(N_BTN), .MAX_RND(MAX_RND), .PW(PW),
        .SHOW_TK(SHOW_TK), .TOUT_TK(TOUT_TK), .SEED(SEED)
    ) dut (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    // Reference colour source: Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
    logic [15:0] m_lfsr;
    always @(posedge clk) begin
        if (!reset_n) m_lfsr <= SEED;
        else          m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    int         checks = 0;
    int         errors = 0;
    logic [1:0] seq_m [MAX_RND];
    int         rnd_m, idx_m, tgt_m, pts_m;
    bit         rev_m;
    logic [3:0] exp_play [$];
    int         tph = 0;
    int         tick_per = 2;
    bit         auto_tick = 1'b1;
    bit         noise = 1'b0;
    bit         prev_play = 1'b0;
    logic [3:0] prev_leds = '0;
    int         match_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive pending inputs, sample 1 time unit after the edge.
    task automatic step();
        if (auto_tick) begin
            bus.tick_i = (tph == 0);
            tph = (tph + 1 >= tick_per) ? 0 : tph + 1;
        end
        if (noise && prev_play && bus.btn_i == '0) bus.btn_i = 4'($urandom_range(15, 1));
        @(posedge clk);
        #1;
        bus.tick_i  = 1'b0;
        bus.start_i = 1'b0;
        bus.btn_i   = '0;
        if (bus.match_o) match_cnt++;
        if (bus.play_o && bus.leds_o != '0 && !(prev_play && prev_leds != '0)) begin
            if (exp_play.size() == 0) chk("play_extra", bus.leds_o, 0);
            else                      chk("play_led", bus.leds_o, exp_play.pop_front());
        end
        prev_play = bus.play_o;
        prev_leds = bus.leds_o;
    endtask

    // Called in the GEN cycle: the engine stores the colour visible now.
    task automatic gen_model();
        seq_m[rnd_m] = m_lfsr[1:0];
        rnd_m++;
        idx_m = 0;
        for (int i = 0; i < rnd_m; i++) exp_play.push_back(4'b0001 << seq_m[i]);
    endtask

    task automatic start_game(input int tgt, input bit rev);
        bus.target_i = RW'(tgt);
        bus.rev_i    = rev;
        bus.start_i  = 1'b1;
        step();
        bus.target_i = '0;
        bus.rev_i    = 1'b0;
        tgt_m = (tgt == 0 || tgt > MAX_RND) ? MAX_RND : tgt;
        rev_m = rev;
        rnd_m = 0;
        pts_m = 0;
        exp_play.delete();
        chk("start_busy", bus.busy_o, 1);
        chk("start_round", bus.round_o, 0);
        chk("start_points", bus.points_o, 0);
        chk("start_flags", {bus.win_o, bus.lose_o, bus.end_time_o}, 0);
        gen_model();
    endtask

    task automatic play_round();
        int n;
        n = 0;
        step();
        chk("show_first", bus.leds_o, 4'b0001 << seq_m[0]);
        while (bus.play_o && n < 5000) begin
            step();
            n++;
        end
        chk("play_bound", n < 5000, 1);
        chk("play_all", exp_play.size(), 0);
        chk("round", bus.round_o, rnd_m);
        chk("wait_state", {bus.busy_o, bus.play_o}, 2'b10);
    endtask

    // res: 0 more presses, 1 round done (GEN), 2 win, 3 lose
    task automatic press(input logic [3:0] b, output int res);
        logic [1:0] e;
        bit ok;
        e  = rev_m ? seq_m[rnd_m - 1 - idx_m] : seq_m[idx_m];
        ok = (b == (4'b0001 << e));
        bus.btn_i = b;
        step();
        if (ok) begin
            pts_m = (pts_m >= 255) ? 255 : pts_m + 1;
            idx_m++;
            chk("match", bus.match_o, 1);
            chk("points", bus.points_o, pts_m);
            if (idx_m == rnd_m) begin
                if (rnd_m == tgt_m) begin
                    res = 2;
                    chk("win", {bus.win_o, bus.lose_o, bus.busy_o}, 3'b100);
                    chk("win_leds", bus.leds_o, 0);
                end else begin
                    res = 1;
                    chk("gen_flash", bus.leds_o, b);
                    chk("gen_busy", bus.busy_o, 1);
                    gen_model();
                end
            end else begin
                res = 0;
                chk("flash", bus.leds_o, b);
            end
        end else begin
            res = 3;
            chk("lose", {bus.win_o, bus.lose_o, bus.busy_o, bus.match_o}, 4'b0100);
        end
    endtask

    task automatic answer_round(output int res);
        int n;
        logic [1:0] e;
        n = rnd_m;
        res = 0;
        for (int i = 0; i < n && res == 0; i++) begin
            e = rev_m ? seq_m[n - 1 - i] : seq_m[i];
            press(4'b0001 << e, res);
        end
    endtask

    task automatic play_game(input int tgt, input bit rev, output int res);
        start_game(tgt, rev);
        res = 1;
        for (int r = 0; r <= MAX_RND && res == 1; r++) begin
            play_round();
            answer_round(res);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int res;
        int n;
        bus.tick_i = 1'b0; bus.start_i = 1'b0; bus.rev_i = 1'b0;
        bus.target_i = '0; bus.btn_i = '0;

        // Reset held 3 cycles with start asserted
        reset_n = 1'b0;
        repeat (3) begin
            bus.start_i = 1'b1;
            step();
        end
        chk("rst_status", {bus.busy_o, bus.play_o, bus.match_o, bus.end_time_o, bus.win_o, bus.lose_o}, 0);
        chk("rst_leds", bus.leds_o, 0);
        chk("rst_round", bus.round_o, 0);
        chk("rst_points", bus.points_o, 0);
        reset_n = 1'b1;
        step();
        chk("idle_busy", bus.busy_o, 0);
        chk("idle_leds", bus.leds_o, 0);

        // Win path, target 2, buttons rattled during playback
        tick_per = 3;
        noise = 1'b1;
        match_cnt = 0;
        start_game(2, 1'b0);
        play_round();
        answer_round(res);
        chk("win_r1_res", res, 1);
        play_round();
        bus.start_i = 1'b1;
        step();
        chk("busy_start_round", bus.round_o, 2);
        chk("busy_start_busy", bus.busy_o, 1);
        answer_round(res);
        chk("win_res", res, 2);
        chk("win_points", bus.points_o, 3);
        chk("win_match_cnt", match_cnt, 3);
        noise = 1'b0;

        // Reset in the middle of playback
        start_game(2, 1'b0);
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        exp_play.delete();
        chk("abort_leds", bus.leds_o, 0);
        chk("abort_status", {bus.busy_o, bus.play_o, bus.win_o, bus.lose_o}, 0);
        chk("abort_round", bus.round_o, 0);
        step();

        // Reverse entry, answered reversed
        play_game(3, 1'b1, res);
        chk("rev_win", res, 2);
        chk("rev_points", bus.points_o, 6);

        // Reverse mode answered in forward order loses at first difference
        start_game(0, 1'b1);
        res = 0;
        for (int r = 0; r < MAX_RND && res < 2; r++) begin
            play_round();
            n = rnd_m;
            for (int i = 0; i < n && res < 2; i++) press(4'b0001 << seq_m[i], res);
        end
        chk("rev_fwd_res", res, 3);
        chk("rev_fwd_lose", bus.lose_o, 1);
        chk("rev_fwd_end_time", bus.end_time_o, 0);

        // Restart from LOSE, then timeout
        start_game(3, 1'b0);
        play_round();
        chk("restart_points", bus.points_o, 0);
        answer_round(res);
        chk("to_r1_res", res, 1);
        play_round();
        auto_tick = 1'b0;
        repeat (3) begin
            bus.tick_i = 1'b1;
            step();
        end
        bus.tick_i = 1'b1;
        press(4'b0001 << seq_m[0], res);
        chk("to_press_res", res, 0);
        repeat (3) step();
        repeat (4) begin
            bus.tick_i = 1'b1;
            step();
        end
        chk("to_4_ticks", {bus.lose_o, bus.end_time_o, bus.busy_o}, 3'b001);
        bus.tick_i = 1'b1;
        step();
        chk("to_5th_tick", {bus.lose_o, bus.end_time_o, bus.busy_o}, 3'b110);
        auto_tick = 1'b1;

        // Two buttons at once
        start_game(2, 1'b0);
        play_round();
        press(4'b0011, res);
        chk("two_bit_res", res, 3);
        chk("two_bit_end_time", bus.end_time_o, 0);

        // target 0 plays all MAX_RND rounds; points saturate on the way
        tick_per = 1;
        play_game(0, 1'b0, res);
        chk("full_win", res, 2);
        chk("full_round", bus.round_o, MAX_RND);
        chk("full_points", bus.points_o, 255);
        step();
        chk("full_hold", {bus.win_o, bus.busy_o, 4'(bus.leds_o)}, 6'b100000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
